pkt_stim_driver: RTL and testbench

- Parametrised successor of the single-channel operand BFM.
- Accepts whole stimulus packages over a valid/ready handshake and slices each one into beats of NUM_CH operand pairs (A, B).
- Drives the beats to the DUT with output backpressure, and reports package and beat progress.
- Sits between the cocotb/testbench stimulus source and the adder DUT (MyTopLevel-class) inside the bench top.

---
 rtl/drv_pkg.sv | 19 +
 rtl/exp_fifo.sv | 54 +++++
 rtl/pkt_stim_driver.sv | 174 +++++++++++++++++
 tb/tb_pkt_stim_driver.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drv_pkg.sv
// Shared types and helpers for the packet stimulus driver.
// The checker feature is enabled by the DRV_CHECK_EN macro.
package drv_pkg;

  // Driver FSM: waiting for a package, or streaming its beats out.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drv_state_e;

  // Width of the package and error counters.
  localparam int CNT_W = 16;

  // Number of beats that one package slices into.
  function automatic int beats_f(input int pkg_w, input int dw, input int nch);
    return pkg_w / (2 * dw * nch);
  endfunction

endpackage

// File: rtl/exp_fifo.sv
// Synchronous FIFO that holds expected results for the driver's checker.
// Read data is show-ahead: rdata_o is the head entry while empty_o is low.
// A push at full is accepted when a pop happens in the same cycle.
module exp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("exp_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit tells full (wrapped) apart from empty (aligned).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pkt_stim_driver.sv
// Packet stimulus driver: accepts whole packages over valid/ready and streams
// them as beats of NUM_CH operand pairs (A, B) with output backpressure.
// Build option DRV_CHECK_EN adds an expected-result FIFO and result checker.
module pkt_stim_driver
  import drv_pkg::*;
#(
  parameter int PACKAGE_WIDTH = 1600,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CH        = 1,
  parameter int EXP_DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [PACKAGE_WIDTH-1:0]     pkt_data,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] op_a,
  output logic [NUM_CH*DATA_WIDTH-1:0] op_b,
  output logic                         pkt_done,
  output logic [CNT_W-1:0]             pkt_cnt,
  input  logic [NUM_CH*DATA_WIDTH-1:0] res_i,
  input  logic                         res_valid_i,
  output logic                         err,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int BEATS     = beats_f(PACKAGE_WIDTH, DATA_WIDTH, NUM_CH);
  localparam int BEAT_BITS = 2 * DATA_WIDTH * NUM_CH;
  localparam int LANE_W    = NUM_CH * DATA_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (BEATS == 0 || BEATS * BEAT_BITS != PACKAGE_WIDTH) begin : g_bad_cfg
    $error("pkt_stim_driver: PACKAGE_WIDTH must be a nonzero multiple of 2*DATA_WIDTH*NUM_CH");
  end

  drv_state_e               state_q, state_d;
  logic [PACKAGE_WIDTH-1:0] sr_q, sr_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     done_q, done_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     live_q;
  logic                     chk_stall;
  logic                     beat_fire, last_beat, pkt_fire;

  // Handshake decode. pkt_ready also opens on the final beat so a following
  // package loads with no bubble; live_q keeps it low through reset.
  assign op_valid  = (state_q == SEND) && !chk_stall;
  assign beat_fire = op_valid && op_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign pkt_ready = live_q && ((state_q == IDLE) || (beat_fire && last_beat));
  assign pkt_fire  = pkt_valid && pkt_ready;

  assign pkt_done  = done_q;
  assign pkt_cnt   = cnt_q;

  // Current beat sits in the low bits of the shift register, A below B per channel.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      op_a[c*DATA_WIDTH +: DATA_WIDTH] = sr_q[c*2*DATA_WIDTH +: DATA_WIDTH];
      op_b[c*DATA_WIDTH +: DATA_WIDTH] = sr_q[c*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic: advance beats, finish packages, load new packages.
  // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: ;
      SEND: begin
        if (beat_fire) begin
          if (last_beat) begin
            // Shift register is left alone so op_a/op_b keep the last beat.
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end else begin
            sr_d   = sr_q >> BEAT_BITS;
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pkt_fire) begin
      sr_d    = pkt_data;
      beat_d  = '0;
      state_d = SEND;
    end
  end

  // Driver state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

`ifdef DRV_CHECK_EN
  logic [LANE_W-1:0] exp_sum, exp_head;
  logic              fifo_full, fifo_empty, mismatch;
  logic              err_q;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Per-channel expected sum of the beat being handed over.
  always_comb begin
    exp_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_sum[c*DATA_WIDTH +: DATA_WIDTH] = op_a[c*DATA_WIDTH +: DATA_WIDTH] +
                                            op_b[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  exp_fifo #(
    .WIDTH(LANE_W),
    .DEPTH(EXP_DEPTH)
  ) u_exp_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .push_i (beat_fire),
    .wdata_i(exp_sum),
    .pop_i  (res_valid_i),
    .rdata_o(exp_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // A result with nothing expected is an error in its own right.
  assign chk_stall = fifo_full;
  assign mismatch  = res_valid_i && (fifo_empty || (exp_head != res_i));
  assign err_cnt_d = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  // Error pulse and saturating error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= mismatch;
      err_cnt_q <= err_cnt_d;
    end
  end
`else
  logic unused_chk;

  assign unused_chk = ^{res_i, res_valid_i, LANE_W'(0)};
  assign chk_stall  = 1'b0;
  assign err        = 1'b0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_pkt_stim_driver.sv
// Directed bench for pkt_stim_driver: default geometry, a 2-channel 16-bit
// geometry and a single-beat geometry, plus the result checker when built in.
module tb_pkt_stim_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default instance: 1600-bit packages, 8-bit operands, 1 channel.
  logic          pkt_valid = 1'b0, pkt_ready;
  logic [1599:0] pkt_data = '0;
  logic          op_valid, op_ready = 1'b0;
  logic [7:0]    op_a, op_b;
  logic          pkt_done;
  logic [15:0]   pkt_cnt;
  logic [7:0]    res_i;
  logic          res_valid_i;
  logic          err;
  logic [15:0]   err_cnt;

  // Manual result stimulus; optionally replaced by an automatic responder.
  logic [7:0] man_d = '0;
  logic       man_v = 1'b0;

`ifdef DRV_CHECK_EN
  logic       auto_res = 1'b1;
  logic       auto_v;
  logic [7:0] auto_d;
  // Returns the correct sum one cycle after every accepted beat.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_v <= 1'b0;
      auto_d <= '0;
    end else begin
      auto_v <= op_valid && op_ready;
      auto_d <= op_a + op_b;
    end
  end
  assign res_valid_i = auto_res ? auto_v : man_v;
  assign res_i       = auto_res ? auto_d : man_d;
`else
  assign res_valid_i = man_v;
  assign res_i       = man_d;
`endif

  pkt_stim_driver dut (
    .clk(clk), .reset_n(reset_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pkt_done(pkt_done), .pkt_cnt(pkt_cnt),
    .res_i(res_i), .res_valid_i(res_valid_i), .err(err), .err_cnt(err_cnt)
  );

  // Wide instance: 256-bit packages, 16-bit operands, 2 channels -> 4 beats.
  logic         w_pkt_valid = 1'b0, w_pkt_ready;
  logic [255:0] w_pkt_data = '0;
  logic         w_op_valid, w_op_ready = 1'b0;
  logic [31:0]  w_op_a, w_op_b;
  logic         w_pkt_done, w_err;
  logic [15:0]  w_pkt_cnt, w_err_cnt;
  logic [31:0]  w_res_i = '0;
  logic         w_res_valid_i = 1'b0;

  pkt_stim_driver #(.PACKAGE_WIDTH(256), .DATA_WIDTH(16), .NUM_CH(2)) dut_wide (
    .clk(clk), .reset_n(reset_n),
    .pkt_valid(w_pkt_valid), .pkt_ready(w_pkt_ready), .pkt_data(w_pkt_data),
    .op_valid(w_op_valid), .op_ready(w_op_ready), .op_a(w_op_a), .op_b(w_op_b),
    .pkt_done(w_pkt_done), .pkt_cnt(w_pkt_cnt),
    .res_i(w_res_i), .res_valid_i(w_res_valid_i), .err(w_err), .err_cnt(w_err_cnt)
  );

  // Single-beat instance: 16-bit packages, 8-bit operands, 1 channel.
  logic        s_pkt_valid = 1'b0, s_pkt_ready;
  logic [15:0] s_pkt_data = '0;
  logic        s_op_valid, s_op_ready = 1'b0;
  logic [7:0]  s_op_a, s_op_b;
  logic        s_pkt_done, s_err;
  logic [15:0] s_pkt_cnt, s_err_cnt;
  logic [7:0]  s_res_i = '0;
  logic        s_res_valid_i = 1'b0;

  pkt_stim_driver #(.PACKAGE_WIDTH(16), .DATA_WIDTH(8), .NUM_CH(1)) dut_one (
    .clk(clk), .reset_n(reset_n),
    .pkt_valid(s_pkt_valid), .pkt_ready(s_pkt_ready), .pkt_data(s_pkt_data),
    .op_valid(s_op_valid), .op_ready(s_op_ready), .op_a(s_op_a), .op_b(s_op_b),
    .pkt_done(s_pkt_done), .pkt_cnt(s_pkt_cnt),
    .res_i(s_res_i), .res_valid_i(s_res_valid_i), .err(s_err), .err_cnt(s_err_cnt)
  );

  // Package whose byte i holds base+i (mod 256).
  function automatic logic [1599:0] mk_pkt(input logic [7:0] base);
    logic [1599:0] p;
    p = '0;
    for (int i = 0; i < 200; i++) p[8*i +: 8] = 8'(base + 8'(i));
    return p;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (pkt_ready !== 1'b0) begin failures++; $display("FAIL rst_pkt_ready got=%b exp=0", pkt_ready); end
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL rst_op_valid got=%b exp=0", op_valid); end
    checks++; if (op_a !== 8'h00 || op_b !== 8'h00) begin failures++; $display("FAIL rst_op got a=%h b=%h exp 00 00", op_a, op_b); end
    checks++; if (pkt_done !== 1'b0) begin failures++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done); end
    checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL rst_pkt_cnt got=%0d exp=0", pkt_cnt); end
    checks++; if (err !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL rst_err got=%b/%0d exp 0/0", err, err_cnt); end
    reset_n = 1'b1;
    step();
    step();
    checks++; if (pkt_ready !== 1'b1) begin failures++; $display("FAIL idle_pkt_ready got=%b exp=1", pkt_ready); end
  endtask

  task automatic test_reset_mid();
    pkt_data  = mk_pkt(8'h00);
    pkt_valid = 1'b1;
    op_ready  = 1'b1;
    step();
    pkt_valid = 1'b0;
    for (int i = 0; i < 37; i++) step();
    checks++; if (op_valid !== 1'b1 || op_a !== 8'h4A || op_b !== 8'h4B) begin
      failures++; $display("FAIL mid_beat37 got v=%b a=%h b=%h exp 1 4a 4b", op_valid, op_a, op_b);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", op_valid); end
    checks++; if (op_a !== 8'h00 || op_b !== 8'h00) begin failures++; $display("FAIL mid_async_op got a=%h b=%h exp 00 00", op_a, op_b); end
    step();
    reset_n = 1'b1;
    step();
    step();
    checks++; if (pkt_cnt !== 16'd0 || pkt_done !== 1'b0) begin failures++; $display("FAIL mid_cnt got cnt=%0d done=%b exp 0 0", pkt_cnt, pkt_done); end
  endtask

  task automatic test_single();
    int got = 0;
    int dones = 0;
    int guard = 0;
    pkt_data  = mk_pkt(8'h00);
    pkt_valid = 1'b1;
    op_ready  = 1'b1;
    #1;
    checks++; if (pkt_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", pkt_ready); end
    step();
    pkt_valid = 1'b0;
    while (got < 100 && guard < 400) begin
      guard++;
      if (pkt_done) dones++;
      if (op_valid) begin
        checks++; if (op_a !== 8'(2*got) || op_b !== 8'(2*got+1)) begin
          failures++; $display("FAIL single_beat%0d got a=%h b=%h exp %h %h", got, op_a, op_b, 8'(2*got), 8'(2*got+1));
        end
        got++;
      end
      step();
    end
    checks++; if (got !== 100) begin failures++; $display("FAIL single_timeout got=%0d beats exp=100", got); end
    checks++; if (dones !== 0) begin failures++; $display("FAIL single_early_done got=%0d exp=0", dones); end
    checks++; if (pkt_done !== 1'b1 || pkt_cnt !== 16'd1) begin failures++; $display("FAIL single_done got done=%b cnt=%0d exp 1 1", pkt_done, pkt_cnt); end
    checks++; if (op_valid !== 1'b0 || op_a !== 8'hC6 || op_b !== 8'hC7) begin
      failures++; $display("FAIL single_hold got v=%b a=%h b=%h exp 0 c6 c7", op_valid, op_a, op_b);
    end
    step();
    checks++; if (pkt_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", pkt_done); end
  endtask

  task automatic test_stall();
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [7:0] ha, hb;
    pkt_data  = mk_pkt(8'h20);
    pkt_valid = 1'b1;
    op_ready  = 1'b1;
    step();
    pkt_valid = 1'b0;
    while (got < 100 && cyc < 400) begin
      op_ready = !(cyc == 6 || cyc == 7);
      if (held) begin
        checks++; if (op_valid !== 1'b1 || op_a !== ha || op_b !== hb) begin
          failures++; $display("FAIL stall_hold cyc%0d got v=%b a=%h b=%h exp 1 %h %h", cyc, op_valid, op_a, op_b, ha, hb);
        end
      end
      held = op_valid && !op_ready;
      ha = op_a;
      hb = op_b;
      if (op_valid && op_ready) begin
        checks++; if (op_a !== 8'(8'h20 + 2*got) || op_b !== 8'(8'h21 + 2*got)) begin
          failures++; $display("FAIL stall_beat%0d got a=%h b=%h exp %h %h", got, op_a, op_b, 8'(8'h20 + 2*got), 8'(8'h21 + 2*got));
        end
        got++;
      end
      cyc++;
      step();
    end
    checks++; if (got !== 100 || cyc !== 102) begin failures++; $display("FAIL stall_count got beats=%0d cycles=%0d exp 100 102", got, cyc); end
    checks++; if (pkt_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int gaps = 0;
    int pk = 0;
    int guard = 0;
    logic fire;
    logic [7:0] ea, eb;
    pkt_data  = mk_pkt(8'h40);
    pkt_valid = 1'b1;
    op_ready  = 1'b1;
    while (got < 200 && guard < 600) begin
      guard++;
      #1;
      fire = pkt_valid && pkt_ready;
      if (op_valid) begin
        ea = (got < 100) ? 8'(8'h40 + 2*got) : 8'(8'h90 + 2*(got-100));
        eb = ea + 8'd1;
        checks++; if (op_a !== ea || op_b !== eb) begin
          failures++; $display("FAIL b2b_beat%0d got a=%h b=%h exp %h %h", got, op_a, op_b, ea, eb);
        end
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      step();
      if (fire) begin
        pk++;
        if (pk == 1) pkt_data = mk_pkt(8'h90);
        else pkt_valid = 1'b0;
      end
    end
    checks++; if (got !== 200 || pk !== 2) begin failures++; $display("FAIL b2b_count got beats=%0d pkts=%0d exp 200 2", got, pk); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL b2b_gap got=%0d exp=0", gaps); end
    checks++; if (pkt_cnt !== 16'd4 || pkt_done !== 1'b1) begin failures++; $display("FAIL b2b_cnt got cnt=%0d done=%b exp 4 1", pkt_cnt, pkt_done); end
    pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_wide();
    for (int w = 0; w < 16; w++) w_pkt_data[16*w +: 16] = 16'(w + 1);
    w_pkt_valid = 1'b1;
    w_op_ready  = 1'b1;
    step();
    w_pkt_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (w_op_valid !== 1'b1 || w_op_a !== {16'(4*k+3), 16'(4*k+1)} || w_op_b !== {16'(4*k+4), 16'(4*k+2)}) begin
        failures++; $display("FAIL wide_beat%0d got v=%b a=%h b=%h exp 1 %h %h", k, w_op_valid, w_op_a, w_op_b,
                             {16'(4*k+3), 16'(4*k+1)}, {16'(4*k+4), 16'(4*k+2)});
      end
      step();
    end
    checks++; if (w_op_valid !== 1'b0 || w_pkt_done !== 1'b1 || w_pkt_cnt !== 16'd1) begin
      failures++; $display("FAIL wide_done got v=%b done=%b cnt=%0d exp 0 1 1", w_op_valid, w_pkt_done, w_pkt_cnt);
    end
  endtask

  task automatic test_single_beat();
    s_pkt_data  = 16'h0201;
    s_pkt_valid = 1'b1;
    s_op_ready  = 1'b1;
    step();
    s_pkt_data = 16'h0403;
    #1;
    checks++; if (s_op_valid !== 1'b1 || s_op_a !== 8'h01 || s_op_b !== 8'h02 || s_pkt_ready !== 1'b1) begin
      failures++; $display("FAIL one_beat0 got v=%b a=%h b=%h rdy=%b exp 1 01 02 1", s_op_valid, s_op_a, s_op_b, s_pkt_ready);
    end
    step();
    s_pkt_valid = 1'b0;
    checks++; if (s_op_valid !== 1'b1 || s_op_a !== 8'h03 || s_op_b !== 8'h04 || s_pkt_done !== 1'b1 || s_pkt_cnt !== 16'd1) begin
      failures++; $display("FAIL one_beat1 got v=%b a=%h b=%h done=%b cnt=%0d exp 1 03 04 1 1", s_op_valid, s_op_a, s_op_b, s_pkt_done, s_pkt_cnt);
    end
    step();
    checks++; if (s_op_valid !== 1'b0 || s_op_a !== 8'h03 || s_pkt_done !== 1'b1 || s_pkt_cnt !== 16'd2) begin
      failures++; $display("FAIL one_end got v=%b a=%h done=%b cnt=%0d exp 0 03 1 2", s_op_valid, s_op_a, s_pkt_done, s_pkt_cnt);
    end
  endtask

`ifdef DRV_CHECK_EN
  task automatic test_checker();
    logic [1599:0] p;
    int acc = 0;
    auto_res = 1'b0;
    op_ready = 1'b0;
    step();
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL chk_start got=%0d exp=0", err_cnt); end
    p = mk_pkt(8'h00);
    p[31:0] = 32'h2010_02FF;
    pkt_data  = p;
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    op_ready  = 1'b1;
    step();
    op_ready = 1'b0;
    man_v = 1'b1;
    man_d = 8'h01;
    step();
    man_v = 1'b0;
    checks++; if (err !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL chk_match got err=%b cnt=%0d exp 0 0", err, err_cnt); end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    man_v = 1'b1;
    man_d = 8'h00;
    step();
    man_v = 1'b0;
    checks++; if (err !== 1'b1 || err_cnt !== 16'd1) begin failures++; $display("FAIL chk_mismatch got err=%b cnt=%0d exp 1 1", err, err_cnt); end
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_pulse got=%b exp=0", err); end
    op_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (op_valid) acc++;
      step();
    end
    checks++; if (acc !== 8 || op_valid !== 1'b0) begin failures++; $display("FAIL chk_full got beats=%0d v=%b exp 8 0", acc, op_valid); end
    op_ready = 1'b0;
    reset_n  = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    man_v = 1'b1;
    man_d = 8'h00;
    step();
    man_v = 1'b0;
    checks++; if (err !== 1'b1 || err_cnt !== 16'd1) begin failures++; $display("FAIL chk_empty got err=%b cnt=%0d exp 1 1", err, err_cnt); end
    auto_res = 1'b1;
  endtask
`else
  task automatic test_checker();
    man_v = 1'b1;
    man_d = 8'h55;
    step();
    step();
    man_v = 1'b0;
    checks++; if (err !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL chk_off got err=%b cnt=%0d exp 0 0", err, err_cnt); end
    checks++; if (pkt_ready !== 1'b1 || op_valid !== 1'b0) begin failures++; $display("FAIL chk_off_idle got rdy=%b v=%b exp 1 0", pkt_ready, op_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_stall();
    test_back_to_back();
    test_wide();
    test_single_beat();
    test_checker();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
